waveform_capture: RTL and testbench
===================================

WAVEFORM_CAPTURE -- requirements
Module: waveform_capture

Interface
REQ-001 Parameter DEPTH, default 2000: number of 14-bit samples per waveform.
REQ-002 Parameter DECIM, default 1: clocks between stored samples (1 = every clock).
REQ-003 Parameter HOLD_CYCLES, default 72100: clocks acquire is held low for serial readout (2001 records x 36 bit-clocks plus margin).
REQ-004 Clocking SHALL be: one clock, clk; reset is asynchronous and active-high, reset.
REQ-005 clk  in  1  system/bit clock, all logic on rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 adc_data  in  14  ADC sample, unsigned, valid every clock.
REQ-008 ext_trig  in  1  asynchronous external trigger, rising edge active.
REQ-009 trig_src  in  1  0 = level trigger on adc_data, 1 = ext_trig.
REQ-010 trig_level  in  14  level-trigger threshold, unsigned.
REQ-011 arm_en  in  1  1 = rearm automatically after each readout.
REQ-012 waveform  out  14 x DEPTH  captured sample array, index 0 = trigger sample.
REQ-013 waveNumber  out  16  count of completed captures.
REQ-014 acquire  out  1  1 = capturing/armed; 0 = array stable, downstream may transmit.
REQ-015 capture_index  out  11  debug: next write index.

Function
REQ-016 adc_data SHALL be registered once; all trigger and storage logic uses the registered sample (1-clock input latency).
REQ-017 ext_trig SHALL pass a 2-flop synchroniser; edge = synchronised now 1, previous 0.
REQ-018 FSM states IDLE, ARMED, CAPTURE, HOLD; acquire = 0 only in HOLD.
REQ-019 IDLE -> ARMED when arm_en = 1; ARMED -> IDLE when arm_en = 0 and no trigger that cycle.
REQ-020 Level trigger: previous registered sample < trig_level and current >= trig_level; first sample after entering ARMED only loads previous, cannot trigger.
REQ-021 On trigger in ARMED: current registered sample written to waveform[0], capture_index = 1, state -> CAPTURE, same clock.
REQ-022 CAPTURE: write registered sample to waveform[capture_index] every DECIM-th clock after the trigger clock, then increment capture_index.
REQ-023 Write of index DEPTH-1: state -> HOLD, waveNumber += 1 (16-bit wrap, 0xFFFF -> 0x0000), acquire = 0 from next clock.
REQ-024 arm_en deassert during CAPTURE SHALL NOT abort; capture completes.
REQ-025 Triggers outside ARMED SHALL be ignored (no queuing).
REQ-026 HOLD: waveform and waveNumber SHALL NOT change; counter runs HOLD_CYCLES clocks, then -> ARMED if arm_en = 1 else IDLE, acquire = 1, capture_index = 0.

Reset
REQ-027 reset SHALL force: state IDLE, acquire = 1, waveNumber = 0, capture_index = 0, decimation/hold counters 0, synchroniser and previous-sample registers 0.
REQ-028 waveform contents SHALL NOT be reset (storage keeps prior data).
REQ-029 reset mid-CAPTURE or mid-HOLD SHALL abandon the capture without incrementing waveNumber.

Structure
REQ-030 Package waveform_capture_pkg SHALL hold the state enum, SAMPLE_W = 14, and default DEPTH/HOLD_CYCLES constants.
REQ-031 Sub-module waveform_trigger SHALL contain synchroniser, previous-sample register, and both trigger detectors, outputting a 1-clock trigger pulse.

Verification
REQ-032 Level: DEPTH=8, DECIM=1, trig_level=0x1000, ramp 0x0F00 step 0x80 -> waveform[0]=0x1000, waveform[7]=0x1380, waveNumber=1, acquire low 1 clock after last write.
REQ-033 Ext: trig_src=1, ext_trig pulse 3 clocks -> exactly one capture, first write 3 clocks after ext_trig rise (2 sync + edge).
REQ-034 Decimation: DECIM=4, DEPTH=4, ramp +1/clock from trigger value 100 -> waveform = 100,104,108,112.
REQ-035 Hold: HOLD_CYCLES=10, arm_en=1, triggers during HOLD -> ignored, waveform unchanged, acquire returns 1 after 10 clocks, second trigger gives waveNumber=2.
REQ-036 Reset at capture_index=5 of DEPTH=8 -> acquire=1, waveNumber=0 immediately; state IDLE.
REQ-037 Wrap: preload 0xFFFF captures (force) -> next capture yields waveNumber=0x0000.

Source files
------------

// File: rtl/waveform_capture_pkg.sv
// Shared types and constants for the waveform capture block.
package waveform_capture_pkg;

  localparam int SAMPLE_W            = 14;
  localparam int INDEX_W             = 11;
  localparam int WAVE_NUM_W          = 16;
  localparam int DEFAULT_DEPTH       = 2000;
  localparam int DEFAULT_HOLD_CYCLES = 72100;

  // Capture FSM: acquire is low only while HOLD keeps the array stable.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/waveform_trigger.sv
// Trigger detection: external-edge synchroniser plus level-crossing
// detector on the registered ADC sample. Emits a one-clock pulse.
module waveform_trigger
  import waveform_capture_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                ext_trig,
  input  logic                trig_src,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                armed,
  output logic                trig
);

  logic                ext_meta;
  logic                ext_sync;
  logic                ext_prev;
  logic [SAMPLE_W-1:0] prev_sample;
  logic                prev_valid;
  logic                ext_edge;
  logic                level_edge;

  // Synchronise ext_trig, remember previous sample; prev_valid is clear on
  // the first armed cycle so that cycle can only load the previous sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_meta    <= 1'b0;
      ext_sync    <= 1'b0;
      ext_prev    <= 1'b0;
      prev_sample <= '0;
      prev_valid  <= 1'b0;
    end else begin
      ext_meta    <= ext_trig;
      ext_sync    <= ext_meta;
      ext_prev    <= ext_sync;
      prev_sample <= sample;
      prev_valid  <= armed;
    end
  end

  assign ext_edge   = ext_sync & ~ext_prev;
  assign level_edge = prev_valid && (prev_sample < trig_level) && (sample >= trig_level);
  assign trig       = trig_src ? ext_edge : level_edge;

endmodule

// File: rtl/waveform_capture.sv
// Triggered waveform capture: records DEPTH samples starting at the trigger
// sample, then holds the array stable (acquire low) for serial readout.
// DEPTH must be at least 2.
module waveform_capture
  import waveform_capture_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int DECIM       = 1,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [SAMPLE_W-1:0]              adc_data,
  input  logic                             ext_trig,
  input  logic                             trig_src,
  input  logic [SAMPLE_W-1:0]              trig_level,
  input  logic                             arm_en,
  output logic [DEPTH-1:0][SAMPLE_W-1:0]   waveform,
  output logic [WAVE_NUM_W-1:0]            waveNumber,
  output logic                             acquire,
  output logic [INDEX_W-1:0]               capture_index,
  output state_t                           fsm_state
);

  localparam int DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DEC_W-1:0]   DEC_LAST  = DEC_W'(DECIM - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [INDEX_W-1:0] IDX_LAST  = INDEX_W'(DEPTH - 1);

  logic [SAMPLE_W-1:0] sample_q;
  logic [DEC_W-1:0]    dec_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                armed;
  logic                trig;
  logic                dec_tick;
  logic                wr_en;
  logic [INDEX_W-1:0]  wr_idx;

  // Single input register; everything downstream sees this sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sample_q <= '0;
    else       sample_q <= adc_data;
  end

  assign armed = (fsm_state == ARMED);

  waveform_trigger u_trigger (
    .clk        (clk),
    .reset      (reset),
    .sample     (sample_q),
    .ext_trig   (ext_trig),
    .trig_src   (trig_src),
    .trig_level (trig_level),
    .armed      (armed),
    .trig       (trig)
  );

  // Trigger clock writes slot 0; afterwards every DECIM-th clock writes.
  assign dec_tick = (dec_cnt == DEC_LAST);
  assign wr_en    = (armed && trig) || ((fsm_state == CAPTURE) && dec_tick);
  assign wr_idx   = armed ? '0 : capture_index;

  // Capture FSM with registered acquire, index, wave counter and timers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_state     <= IDLE;
      acquire       <= 1'b1;
      waveNumber    <= '0;
      capture_index <= '0;
      dec_cnt       <= '0;
      hold_cnt      <= '0;
    end else begin
      case (fsm_state)
        IDLE: begin
          if (arm_en) fsm_state <= ARMED;
        end
        ARMED: begin
          if (trig) begin
            fsm_state     <= CAPTURE;
            capture_index <= INDEX_W'(1);
            dec_cnt       <= '0;
          end else if (!arm_en) begin
            fsm_state <= IDLE;
          end
        end
        CAPTURE: begin
          if (dec_tick) begin
            dec_cnt       <= '0;
            capture_index <= capture_index + INDEX_W'(1);
            if (capture_index == IDX_LAST) begin
              fsm_state  <= HOLD;
              acquire    <= 1'b0;
              waveNumber <= waveNumber + WAVE_NUM_W'(1);
              hold_cnt   <= '0;
            end
          end else begin
            dec_cnt <= dec_cnt + DEC_W'(1);
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt      <= '0;
            capture_index <= '0;
            acquire       <= 1'b1;
            fsm_state     <= arm_en ? ARMED : IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: fsm_state <= IDLE;
      endcase
    end
  end

  // Sample storage is deliberately not reset so prior data survives.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_idx == INDEX_W'(i))) waveform[i] <= sample_q;
    end
  end

endmodule

// File: tb/tb_waveform_capture.sv
// Directed bench for waveform_capture: level/ext triggering, decimation,
// hold behaviour, reset abandonment and wave counter wrap.
module tb_waveform_capture;
  import waveform_capture_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance: DEPTH=8, DECIM=1, HOLD_CYCLES=10
  logic [13:0]      adc_data;
  logic             ext_trig;
  logic             trig_src;
  logic [13:0]      trig_level;
  logic             arm_en;
  logic [7:0][13:0] wf;
  logic [15:0]      wave_num;
  logic             acquire;
  logic [10:0]      capture_index;
  state_t           fsm_state;

  // decimation instance: DEPTH=4, DECIM=4, HOLD_CYCLES=10
  logic [13:0]      adc_d;
  logic             ext_d;
  logic             src_d;
  logic [13:0]      level_d;
  logic             arm_d;
  logic [3:0][13:0] wf_d;
  logic [15:0]      wave_num_d;
  logic             acquire_d;
  logic [10:0]      index_d;
  state_t           state_d;

  waveform_capture #(.DEPTH(8), .DECIM(1), .HOLD_CYCLES(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .adc_data      (adc_data),
    .ext_trig      (ext_trig),
    .trig_src      (trig_src),
    .trig_level    (trig_level),
    .arm_en        (arm_en),
    .waveform      (wf),
    .waveNumber    (wave_num),
    .acquire       (acquire),
    .capture_index (capture_index),
    .fsm_state     (fsm_state)
  );

  waveform_capture #(.DEPTH(4), .DECIM(4), .HOLD_CYCLES(10)) dut_d (
    .clk           (clk),
    .reset         (reset),
    .adc_data      (adc_d),
    .ext_trig      (ext_d),
    .trig_src      (src_d),
    .trig_level    (level_d),
    .arm_en        (arm_d),
    .waveform      (wf_d),
    .waveNumber    (wave_num_d),
    .acquire       (acquire_d),
    .capture_index (index_d),
    .fsm_state     (state_d)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_acq(input logic level, input int budget, input string tag);
    int n = 0;
    while (acquire !== level && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(acquire), 32'(level));
  endtask

  task automatic wait_index(input logic [10:0] idx, input int budget, input string tag);
    int n = 0;
    while (capture_index !== idx && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(capture_index), 32'(idx));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; adc_data = '0; ext_trig = 1'b0; trig_src = 1'b0;
    trig_level = 14'h1000; arm_en = 1'b0;
    adc_d = '0; ext_d = 1'b0; src_d = 1'b0; level_d = 14'd100; arm_d = 1'b0;
    repeat (2) step();
    check("rst_acquire", 32'(acquire), 32'd1);
    check("rst_wavenum", 32'(wave_num), 32'd0);
    check("rst_index",   32'(capture_index), 32'd0);
    check("rst_state",   32'(fsm_state), 32'(IDLE));
    reset = 1'b0;
    step();

    // decimation: DEPTH=4, DECIM=4, ramp +1 from trigger value 100
    arm_d = 1'b1; adc_d = 14'd90;
    repeat (3) step();
    for (int k = 0; k < 20; k++) begin
      adc_d = 14'(100 + k);
      step();
    end
    arm_d = 1'b0;
    check("dec_wf0", 32'(wf_d[0]), 32'd100);
    check("dec_wf1", 32'(wf_d[1]), 32'd104);
    check("dec_wf2", 32'(wf_d[2]), 32'd108);
    check("dec_wf3", 32'(wf_d[3]), 32'd112);
    check("dec_wavenum", 32'(wave_num_d), 32'd1);
    check("dec_acquire", 32'(acquire_d), 32'd0);

    // first armed sample only loads previous: a crossing there must not fire
    adc_data = 14'h0F00; step();
    arm_en = 1'b1; adc_data = 14'h1000;
    repeat (3) step();
    check("first_state", 32'(fsm_state), 32'(ARMED));
    check("first_index", 32'(capture_index), 32'd0);

    // level trigger ramp 0x0F00 step 0x80
    for (int k = 0; k < 10; k++) begin
      adc_data = 14'(32'h0F00 + k * 32'h80);
      step();
      if (k == 3) begin
        check("lvl_idx_after_trig", 32'(capture_index), 32'd1);
        check("lvl_wf0_early", 32'(wf[0]), 32'h1000);
      end
    end
    check("lvl_acq_before_last", 32'(acquire), 32'd1);
    check("lvl_idx_before_last", 32'(capture_index), 32'd7);
    adc_data = 14'h1400; step();
    check("lvl_acq_low", 32'(acquire), 32'd0);
    check("lvl_state_hold", 32'(fsm_state), 32'(HOLD));
    check("lvl_wf0", 32'(wf[0]), 32'h1000);
    check("lvl_wf7", 32'(wf[7]), 32'h1380);
    check("lvl_wavenum", 32'(wave_num), 32'd1);

    // hold: crossings ignored, array and counter frozen for 10 clocks
    for (int i = 1; i <= 9; i++) begin
      adc_data = (i % 2 == 1) ? 14'h1FFF : 14'h0000;
      step();
      check("hold_acq", 32'(acquire), 32'd0);
      check("hold_wf0", 32'(wf[0]), 32'h1000);
      check("hold_wf7", 32'(wf[7]), 32'h1380);
      check("hold_wavenum", 32'(wave_num), 32'd1);
    end
    adc_data = 14'h0000; step();
    check("hold_end_acq", 32'(acquire), 32'd1);
    check("hold_end_index", 32'(capture_index), 32'd0);
    check("hold_end_state", 32'(fsm_state), 32'(ARMED));

    // second trigger after rearm
    step();
    adc_data = 14'h1000; step();
    adc_data = 14'h1200;
    wait_acq(1'b0, 20, "cap2_done");
    check("cap2_wavenum", 32'(wave_num), 32'd2);
    check("cap2_wf0", 32'(wf[0]), 32'h1000);
    check("cap2_wf1", 32'(wf[1]), 32'h1200);
    check("cap2_wf7", 32'(wf[7]), 32'h1200);

    // reset at capture_index 5 abandons the capture
    wait_acq(1'b1, 20, "cap2_rearm");
    adc_data = 14'h0000; step(); step();
    adc_data = 14'h1000; step();
    adc_data = 14'h1100;
    wait_index(11'd5, 20, "rstcap_index5");
    reset = 1'b1;
    #1;
    check("rstcap_acquire", 32'(acquire), 32'd1);
    check("rstcap_wavenum", 32'(wave_num), 32'd0);
    check("rstcap_state",   32'(fsm_state), 32'(IDLE));
    check("rstcap_index",   32'(capture_index), 32'd0);
    check("rstcap_wf0_kept", 32'(wf[0]), 32'h1000);
    check("rstcap_wf7_kept", 32'(wf[7]), 32'h1200);
    step();
    reset = 1'b0;

    // external trigger: 3-clock pulse, first write on 3rd clock after rise
    trig_src = 1'b1; arm_en = 1'b1;
    step(); step();
    ext_trig = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      if (j == 4) begin
        ext_trig = 1'b0;
        arm_en   = 1'b0;
      end
      adc_data = 14'(32'h01FF + j);
      step();
      if (j == 2) check("ext_no_write_yet", 32'(capture_index), 32'd0);
      if (j == 3) begin
        check("ext_first_write_idx", 32'(capture_index), 32'd1);
        check("ext_wf0", 32'(wf[0]), 32'h0201);
      end
    end
    check("ext_acq_low", 32'(acquire), 32'd0);
    check("ext_wavenum", 32'(wave_num), 32'd1);
    check("ext_wf7", 32'(wf[7]), 32'h0208);
    wait_acq(1'b1, 20, "ext_hold_end");
    check("ext_idle", 32'(fsm_state), 32'(IDLE));
    check("ext_single_capture", 32'(wave_num), 32'd1);

    // wave counter wrap 0xFFFF -> 0x0000
    trig_src = 1'b0;
    force dut.waveNumber = 16'hFFFF;
    step();
    release dut.waveNumber;
    step();
    check("wrap_preload", 32'(wave_num), 32'hFFFF);
    arm_en = 1'b1; adc_data = 14'h0000;
    step(); step();
    adc_data = 14'h1000; step();
    adc_data = 14'h1100;
    wait_acq(1'b0, 20, "wrap_done");
    check("wrap_wavenum", 32'(wave_num), 32'h0000);
    check("wrap_wf0", 32'(wf[0]), 32'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
